// File: rtl/ser2par_rx_pkg.sv
// Shared types, direction encodings and width helpers for the serial-to-parallel receiver.
`ifndef SER2PAR_DIR_MSB
`define SER2PAR_DIR_MSB 1'b0
`endif
`ifndef SER2PAR_DIR_LSB
`define SER2PAR_DIR_LSB 1'b1
`endif

package ser2par_rx_pkg;

    // Shift direction; encodings follow the shared direction defines.
    typedef enum logic {
        DIR_MSB = `SER2PAR_DIR_MSB,
        DIR_LSB = `SER2PAR_DIR_LSB
    } dir_e;

    // Beat counter width: max(1, clog2(beats)).
    function automatic int unsigned cnt_width(input int unsigned beats);
        return (beats <= 2) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/ser2par_rx_if.sv
// Serial-in / parallel-out handshake bundle for ser2par_rx.
interface ser2par_rx_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SHIFT_NUM  = 1
);
    import ser2par_rx_pkg::*;

    localparam int unsigned BEATS = DATA_WIDTH / SHIFT_NUM;
    localparam int unsigned CNT_W = cnt_width(BEATS);

    logic                  en_i;
    logic                  dir_i;
    logic                  clr_i;
    logic                  ser_vld_i;
    logic                  ser_rdy_o;
    logic [SHIFT_NUM-1:0]  ser_dat_i;
    logic                  par_vld_o;
    logic                  par_rdy_i;
    logic [DATA_WIDTH-1:0] par_data_o;
    logic [CNT_W-1:0]      cnt_o;

    // Receiver side.
    modport slave (
        input  en_i, dir_i, clr_i, ser_vld_i, ser_dat_i, par_rdy_i,
        output ser_rdy_o, par_vld_o, par_data_o, cnt_o
    );

    // Source / sink side.
    modport master (
        output en_i, dir_i, clr_i, ser_vld_i, ser_dat_i, par_rdy_i,
        input  ser_rdy_o, par_vld_o, par_data_o, cnt_o
    );

endinterface

// File: rtl/ser2par_rx_dffr.sv
// Synchronous-reset, load-enabled register primitive (resets to zero).
module ser2par_rx_dffr #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Reset wins over load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/ser2par_rx.sv
// Serial-to-parallel receiver: assembles SHIFT_NUM-bit beats into DATA_WIDTH-bit
// words, MSB- or LSB-first, with a single-entry output buffer.
module ser2par_rx
    import ser2par_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SHIFT_NUM  = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ser2par_rx_if.slave   bus
);

    localparam int unsigned BEATS = DATA_WIDTH / SHIFT_NUM;
    localparam int unsigned CNT_W = cnt_width(BEATS);

    // Reject parameter sets that cannot form whole words.
    if (DATA_WIDTH < 2 || SHIFT_NUM < 1 || (DATA_WIDTH % SHIFT_NUM) != 0) begin : g_param_err
        $error("ser2par_rx: DATA_WIDTH must be >= 2 and a multiple of SHIFT_NUM");
    end

    logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_msb, sr_lsb, sr_nxt, out_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  dir_q, dir_eff, vld_q, vld_d;
    logic                  sr_en, cnt_en, dir_en, out_en;
    logic                  first, last, ser_rdy, beat, consume;

    // Candidate shifted words for both directions.
    if (SHIFT_NUM == DATA_WIDTH) begin : g_full
        assign sr_msb = bus.ser_dat_i;
        assign sr_lsb = bus.ser_dat_i;
    end else begin : g_part
        assign sr_msb = {sr_q[DATA_WIDTH-SHIFT_NUM-1:0], bus.ser_dat_i};
        assign sr_lsb = {bus.ser_dat_i, sr_q[DATA_WIDTH-1:SHIFT_NUM]};
    end

    // Ready, next-state and register load enables.
    always_comb begin
        first   = (cnt_q == '0);
        last    = (cnt_q == CNT_W'(BEATS - 1));
        dir_eff = first ? bus.dir_i : dir_q;
        // Only the last beat stalls when the output buffer is full and not draining.
        ser_rdy = bus.en_i && !bus.clr_i && !(last && vld_q && !bus.par_rdy_i);
        beat    = bus.ser_vld_i && ser_rdy;
        consume = vld_q && bus.par_rdy_i;
        sr_nxt  = (dir_eff == DIR_LSB) ? sr_lsb : sr_msb;

        sr_d    = sr_nxt;
        sr_en   = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
        cnt_en  = 1'b0;
        dir_en  = 1'b0;
        out_en  = 1'b0;
        vld_d   = vld_q;

        if (bus.clr_i) begin
            sr_d   = '0;
            sr_en  = 1'b1;
            cnt_d  = '0;
            cnt_en = 1'b1;
        end else if (beat) begin
            sr_en  = 1'b1;
            cnt_en = 1'b1;
            cnt_d  = last ? '0 : cnt_q + CNT_W'(1);
            dir_en = first;
            out_en = last;
        end

        // A load on the same edge as a consume keeps the buffer full.
        if (beat && last) begin
            vld_d = 1'b1;
        end else if (consume) begin
            vld_d = 1'b0;
        end
    end

    ser2par_rx_dffr #(.W(DATA_WIDTH)) u_sr (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(sr_en), .d_i(sr_d), .q_o(sr_q)
    );

    ser2par_rx_dffr #(.W(CNT_W)) u_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(cnt_en), .d_i(cnt_d), .q_o(cnt_q)
    );

    ser2par_rx_dffr #(.W(1)) u_dir (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(dir_en), .d_i(bus.dir_i), .q_o(dir_q)
    );

    ser2par_rx_dffr #(.W(DATA_WIDTH)) u_out (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(out_en), .d_i(sr_nxt), .q_o(out_q)
    );

    ser2par_rx_dffr #(.W(1)) u_vld (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1), .d_i(vld_d), .q_o(vld_q)
    );

    assign bus.ser_rdy_o  = ser_rdy;
    assign bus.par_vld_o  = vld_q;
    assign bus.par_data_o = out_q;
    assign bus.cnt_o      = cnt_q;

endmodule
